// File: rtl/fwd_scoreboard.sv
// Forwarding and load-use hazard unit. Tracks in-flight register writes in a
// DEPTH-entry shadow pipeline and picks, per operand port, the youngest
// matching producer (or the register file when nothing matches).
module fwd_scoreboard #(
  parameter int DW        = 32,
  parameter int AW        = 5,
  parameter int NREAD     = 2,
  parameter int DEPTH     = 3,
  parameter int LOAD_SLOT = 1
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                issue_valid,
  input  logic                issue_we,
  input  logic [AW-1:0]       issue_rd,
  input  logic                issue_load,
  input  logic                flush,
  input  logic                freeze,
  input  logic [NREAD*AW-1:0] rd_addr,
  input  logic [NREAD*DW-1:0] rf_data,
  input  logic [DEPTH*DW-1:0] slot_data,
  output logic [NREAD*DW-1:0] fwd_data,
  output logic [NREAD-1:0]    fwd_hit,
  output logic                hazard_stall,
  output logic [15:0]         stall_cnt
);

  // Per-slot tracking state; slot 0 is the youngest in-flight instruction.
  logic [DEPTH-1:0] slot_valid;
  logic [DEPTH-1:0] slot_load;
  logic [AW-1:0]    slot_rd [DEPTH];

  // A slot's data is usable once it is not a load, or the load has reached
  // the stage where memory data exists.
  logic [DEPTH-1:0] slot_ready;
  logic [NREAD-1:0] port_haz;

  genvar gi, gs;

  generate
    for (gs = 0; gs < DEPTH; gs++) begin : gen_ready
      assign slot_ready[gs] = ~slot_load[gs] | (gs >= LOAD_SLOT);
    end
  endgenerate

  generate
    for (gi = 0; gi < NREAD; gi++) begin : gen_port
      logic [DEPTH-1:0] match;
      logic [DEPTH-1:0] first;
      logic [DW-1:0]    acc [DEPTH+1];
      logic             win_ready;
      logic             win_busy;

      for (gs = 0; gs < DEPTH; gs++) begin : gen_slot
        // r0 is hardwired, so a pending write to it is never a real producer.
        assign match[gs] = slot_valid[gs]
                           && (slot_rd[gs] == rd_addr[gi*AW +: AW])
                           && (slot_rd[gs] != '0);
        // Only the youngest match counts; older matches are shadowed even
        // when the youngest one is not ready yet.
        if (gs == 0) begin : gen_first0
          assign first[gs] = match[gs];
        end else begin : gen_firstn
          assign first[gs] = match[gs] & ~(|match[gs-1:0]);
        end
        // AND-OR select of the winning slot's data (first is one-hot).
        assign acc[gs+1] = acc[gs]
                           | ({DW{first[gs] & slot_ready[gs]}} & slot_data[gs*DW +: DW]);
      end

      assign acc[0]    = '0;
      assign win_ready = |(first & slot_ready);
      assign win_busy  = |(first & ~slot_ready);

      assign fwd_hit[gi]            = win_ready;
      assign port_haz[gi]           = win_busy;
      assign fwd_data[gi*DW +: DW]  = win_ready ? acc[DEPTH] : rf_data[gi*DW +: DW];
    end
  endgenerate

  // Only an instruction actually leaving ID can be stalled.
  assign hazard_stall = issue_valid & (|port_haz);

  // Slot 0 captures the issuing instruction; stalled or flushed issues become bubbles.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      slot_valid[0] <= 1'b0;
      slot_load[0]  <= 1'b0;
      slot_rd[0]    <= '0;
    end else if (!freeze) begin
      slot_valid[0] <= issue_valid & issue_we & ~flush & ~hazard_stall;
      slot_load[0]  <= issue_load;
      slot_rd[0]    <= issue_rd;
    end
  end

  generate
    for (gs = 1; gs < DEPTH; gs++) begin : gen_shift
      // Older slots advance one stage per unfrozen cycle; the last one retires.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          slot_valid[gs] <= 1'b0;
          slot_load[gs]  <= 1'b0;
          slot_rd[gs]    <= '0;
        end else if (!freeze) begin
          slot_valid[gs] <= slot_valid[gs-1];
          slot_load[gs]  <= slot_load[gs-1];
          slot_rd[gs]    <= slot_rd[gs-1];
        end
      end
    end
  endgenerate

  // Saturating count of stall cycles that actually took effect (not frozen).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt <= 16'd0;
    end else if (hazard_stall && !freeze && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: doc/fwd_scoreboard.md
Name: fwd_scoreboard

Overview:
- Parametrised forwarding and hazard unit for the pipelined CPU.
- Replaces the fixed 3:1 forwarding muxes and the external hazard logic with one block. The block tracks in-flight register writes in a DEPTH-stage shadow pipeline.
- For each of NREAD operand ports it selects the youngest matching in-flight result or the register-file value.
- Raises a load-use stall when the youngest matching producer's data is not yet available. Sits between ID/EX decode and the ALU operand path.

Parameters:
- DW, 32, datapath width.
- AW, 5, register address width.
- NREAD, 2, number of operand read ports.
- DEPTH, 3, tracked stages after issue (slot 0 = EX/MEM, 1 = MEM/WB, 2 = WB-pending).
- LOAD_SLOT, 1, first slot at which load data is valid; range 0..DEPTH-1.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- issue_valid  in  1  instruction leaves ID this cycle.
- issue_we  in  1  instruction writes a register.
- issue_rd  in  AW  destination register.
- issue_load  in  1  instruction is a load.
- flush  in  1  kill the instruction issuing this cycle.
- freeze  in  1  external stall; hold all slots.
- rd_addr  in  NREAD*AW  operand addresses, port p at [p*AW +: AW].
- rf_data  in  NREAD*DW  register-file read data per port.
- slot_data  in  DEPTH*DW  result value held in each slot's pipeline register.
- fwd_data  out  NREAD*DW  operand after forwarding.
- fwd_hit  out  NREAD  1 if port p is forwarded from a slot.
- hazard_stall  out  1  load-use stall request.
- stall_cnt  out  16  saturating count of hazard_stall cycles.

Behaviour:
Slot state and reset:
- Slot state per slot: valid, rd, load. Reset (rstn=0, asynchronous) clears all valid bits and sets stall_cnt to 0.
- With all slots invalid, outputs are: fwd_data=rf_data, fwd_hit=0, hazard_stall=0.

Operand match and forwarding (combinational):
- Slot i matches port p when valid, rd==rd_addr[p], and rd!=0.
- Selection is youngest-first: the lowest matching index wins.
- If no slot matches: fwd_data[p]=rf_data[p] and fwd_hit[p]=0.
- If the winning slot is ready (!load or i>=LOAD_SLOT): fwd_data[p]=slot_data[i] and fwd_hit[p]=1.
- If the winning slot is not ready: fwd_data[p]=rf_data[p], fwd_hit[p]=0, and the port raises a hazard. Older ready matches are never used in this case.

Stall generation:
- hazard_stall = OR of port hazards, gated by issue_valid.
- No stall when issue_valid=0.
- Stall is independent of freeze.

Per-cycle update (posedge clk, in priority order):
- freeze=1: all slots hold; stall_cnt holds.
- Else: slots 1..DEPTH-1 load from slots 0..DEPTH-2; the entry in slot DEPTH-1 retires.
- Slot 0 loads the issuing instruction {valid=issue_valid&issue_we&!flush&!hazard_stall, rd=issue_rd, load=issue_load}.
- A stalled or flushed issue inserts a bubble (valid=0). Upstream holds ID during a stall.
- stall_cnt increments when hazard_stall=1 and freeze=0; it saturates at 16'hFFFF.

Boundary conditions:
- Register r0 is never forwarded and never causes a stall.
- Multiple ports may hit the same slot.
- flush together with hazard_stall produces a bubble; stall_cnt still counts the cycle.
- Reset asserted mid-operation clears in-flight state immediately. Stall deasserts combinationally.

Latency and invariants:
- Forward path latency: 0 cycles. Tracking latency: 1 cycle from issue to slot 0.
- A load with LOAD_SLOT=1 stalls a dependent instruction exactly 1 cycle.
- A load with LOAD_SLOT=k stalls a dependent instruction k cycles.

Test Plan:
- ALU producer forwarding (defaults):
  - Issue add r3 (we=1, load=0), then next cycle read rd_addr[0]=3 with slot_data[0]=0x1234 -> fwd_data[0]=0x1234, fwd_hit[0]=1, hazard_stall=0.
  - One cycle later, read 3 -> value taken from slot 1.
- Load-use stall:
  - Issue lw r5, then next cycle issue_valid=1 reading r5 -> hazard_stall=1 for 1 cycle and a bubble enters slot 0.
  - The following cycle: load in slot 1, fwd_data=slot_data[1], stall_cnt=1.
- Youngest wins: slot 0 and slot 2 both target r7 (slot_data 0xA, 0xC) -> fwd_data=0xA. If slot 0 is a non-ready load -> hazard_stall=1, no fallback to 0xC.
- r0 and no-match: rd_addr=0 with slot 0 rd=0 -> fwd_data=rf_data, fwd_hit=0. Unmatched address -> rf_data.
- freeze and flush:
  - freeze=1 for 3 cycles -> slot contents unchanged and stall_cnt unchanged.
  - flush with issue_we=1 -> slot 0 invalid next cycle; a subsequent read of that rd is not forwarded.
- Reset mid-flight: slots full, drop rstn asynchronously between edges -> fwd_hit=0, hazard_stall=0, stall_cnt=0 before the next clk edge.
- Saturation: hold the stall condition for 70000 cycles -> stall_cnt=0xFFFF with no wrap.
